// File: rtl/memory_sized_if.sv
// Request/response bundle for memory_sized.
//
// Handshake: the master raises start together with a complete request
// (rwn, address, size, sign, data_in). The request is taken on the rising
// edge where start and ready are both high. ready stays low while the access
// is in flight. done pulses for one cycle when the access completes, and
// data_out/err are valid in that cycle. start while ready is low is ignored
// and not queued.
interface memory_sized_if #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_BYTES    = 4
);
   logic                      start;
   logic                      rwn;
   logic [ADDRESS_WIDTH-1:0]  address;
   logic [1:0]                size;
   logic                      sign;
   logic [8*DATA_BYTES-1:0]   data_in;
   logic [8*DATA_BYTES-1:0]   data_out;
   logic                      ready;
   logic                      done;
   logic                      err;

   modport master (
      output start, rwn, address, size, sign, data_in,
      input  data_out, ready, done, err
   );

   modport slave (
      input  start, rwn, address, size, sign, data_in,
      output data_out, ready, done, err
   );
endinterface

// File: rtl/memory_sized.sv
// Byte-addressed little-endian data memory with start/ready handshake,
// byte/half/word access widths, sign or zero extension on reads and a
// programmable number of wait cycles before the access edge.
// Optional feature macro: MEM_ALIGN_CHECK_EN -- when defined, accesses whose
// address is not a multiple of the access width complete without touching
// the array or data_out and raise err together with done.
module memory_sized #(
   parameter int SIZE          = 256,
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_BYTES    = 4,
   parameter int LATENCY       = 0
) (
   input  logic          clk,
   input  logic          reset,
   memory_sized_if.slave bus,
   output logic [1:0]    state_dbg
);

   localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam int DW = 8 * DATA_BYTES;
   // Largest size code that still fits in one word; larger codes are clamped.
   localparam logic [1:0] MAX_CODE = (DATA_BYTES >= 8) ? 2'd3 :
                                     (DATA_BYTES >= 4) ? 2'd2 :
                                     (DATA_BYTES >= 2) ? 2'd1 : 2'd0;
   localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_ACCESS = 2'd2
   } state_t;

   state_t                    state;
   state_t                    state_nxt;
   logic [3:0]                cnt;
   logic [ADDRESS_WIDTH-1:0]  addr_q;
   logic                      rwn_q;
   logic [1:0]                code_q;
   logic                      sign_q;
   logic [DW-1:0]             wdata_q;
   logic [7:0]                mem [0:SIZE-1];
   logic                      accept;
   int                        n_bytes;
   logic [DW-1:0]             rd_raw;
   logic [DW-1:0]             rd_val;
   logic                      sbit;
   logic                      misalign;
   logic                      done_q;
   logic [DW-1:0]             dout_q;

   // Array index of byte k of an access starting at a, wrapping at SIZE.
   function automatic logic [IW-1:0] wrap_idx(input logic [ADDRESS_WIDTH-1:0] a,
                                              input int k);
      int s;
      s = int'(a) + k;
      return IW'(s % SIZE);
   endfunction

   assign accept    = bus.start && (state == S_IDLE);
   assign bus.ready = (state == S_IDLE);
   assign bus.done  = done_q;
   assign bus.data_out = dout_q;
   assign state_dbg = state;

   // Number of bytes touched by the latched request.
   always_comb begin
      n_bytes = 1 << code_q;
   end

`ifdef MEM_ALIGN_CHECK_EN
   logic [ADDRESS_WIDTH-1:0] align_mask;
   logic                     err_q;

   // An access is misaligned when any address bit below the width is set.
   always_comb begin
      align_mask = ADDRESS_WIDTH'(n_bytes - 1);
      misalign   = |(addr_q & align_mask);
   end

   // err pulses alongside done for a rejected misaligned access.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= (state == S_ACCESS) && misalign;
      end
   end

   assign bus.err = err_q;
`else
   assign misalign = 1'b0;
   assign bus.err  = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode: IDLE -> (WAIT) -> ACCESS -> IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_nxt = (LATENCY > 0) ? S_WAIT : S_ACCESS;
            end
         end
         S_WAIT: begin
            if (cnt == 4'd0) begin
               state_nxt = S_ACCESS;
            end
         end
         S_ACCESS: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Latch the request on acceptance and run the wait counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= 4'd0;
         addr_q  <= '0;
         rwn_q   <= 1'b1;
         code_q  <= 2'd0;
         sign_q  <= 1'b0;
         wdata_q <= '0;
      end else begin
         if (accept) begin
            cnt     <= LAT_LOAD;
            addr_q  <= bus.address;
            rwn_q   <= bus.rwn;
            code_q  <= (bus.size > MAX_CODE) ? MAX_CODE : bus.size;
            sign_q  <= bus.sign;
            wdata_q <= bus.data_in;
         end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   // Gather the addressed bytes and extend from the top byte of the access.
   always_comb begin
      rd_raw = '0;
      sbit   = 1'b0;
      for (int k = 0; k < DATA_BYTES; k++) begin
         if (k < n_bytes) begin
            rd_raw[8*k +: 8] = mem[wrap_idx(addr_q, k)];
            if (k == n_bytes - 1) begin
               sbit = rd_raw[8*k+7];
            end
         end
      end
      rd_val = rd_raw;
      for (int k = 0; k < DATA_BYTES; k++) begin
         if (k >= n_bytes) begin
            rd_val[8*k +: 8] = {8{sign_q & sbit}};
         end
      end
   end

   // Storage array: cleared by reset, written only on the ACCESS edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SIZE; i++) begin
            mem[IW'(i)] <= 8'h00;
         end
      end else if ((state == S_ACCESS) && !rwn_q && !misalign) begin
         for (int k = 0; k < DATA_BYTES; k++) begin
            if (k < n_bytes) begin
               mem[wrap_idx(addr_q, k)] <= wdata_q[8*k +: 8];
            end
         end
      end
   end

   // Registered completion pulse and read result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done_q <= 1'b0;
         dout_q <= '0;
      end else begin
         done_q <= (state == S_ACCESS);
         if ((state == S_ACCESS) && rwn_q && !misalign) begin
            dout_q <= rd_val;
         end
      end
   end

endmodule
